// File: rtl/text_buffer_ctrl.sv
// text_buffer_ctrl: 16x16 character buffer with byte-stream cursor writes, clear engine and 1-cycle display read.
// Optional cursor blink is built only when CURSOR_BLINK_EN is defined.
module text_buffer_ctrl #(
  parameter logic [7:0] CLR_CHAR  = 8'h20,
  parameter int         BLINK_DIV = 25_000_000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       clr_req,
  input  logic [7:0] char_xy,
  output logic [7:0] char_code,
  output logic       busy,
  output logic [3:0] cursor_x,
  output logic [3:0] cursor_y,
  output logic       cursor_on
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [7:0] clr_cnt_q, clr_cnt_d, waddr, wdata, char_code_q;
  logic [3:0] cx_q, cx_d, cy_q, cy_d, bx, by;
  logic       we;
  logic [7:0] mem [256];
  assign in_ready  = state_q == IDLE && !clr_req;
  assign busy      = state_q == CLEAR;
  assign char_code = char_code_q;
  assign cursor_x  = cx_q;
  assign cursor_y  = cy_q;
  // backspace target: step back one cell, stay put at the top-left corner
  assign bx = cx_q != 4'd0 ? cx_q - 4'd1 : (cy_q != 4'd0 ? 4'hf : 4'd0);
  assign by = cx_q == 4'd0 && cy_q != 4'd0 ? cy_q - 4'd1 : cy_q;
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    we        = 1'b0;
    waddr     = clr_cnt_q;
    wdata     = CLR_CHAR;
    if (state_q == CLEAR) begin
      we        = 1'b1;
      clr_cnt_d = clr_cnt_q + 8'd1;
      if (clr_cnt_q == 8'hff) begin
        state_d = IDLE;
        cx_d    = 4'd0;
        cy_d    = 4'd0;
      end
    end else if (clr_req) begin
      state_d   = CLEAR;
      clr_cnt_d = 8'd0;
    end else if (in_valid) begin
      if (in_data >= 8'h20 && in_data <= 8'h7e) begin
        we    = 1'b1;
        waddr = {cx_q, cy_q};
        wdata = in_data;
        cx_d  = cx_q + 4'd1;
        cy_d  = cx_q == 4'hf ? cy_q + 4'd1 : cy_q;
      end else if (in_data == 8'h0d) begin
        cx_d = 4'd0;
      end else if (in_data == 8'h0a) begin
        cy_d = cy_q + 4'd1;
      end else if (in_data == 8'h08) begin
        we    = 1'b1;
        waddr = {bx, by};
        cx_d  = bx;
        cy_d  = by;
      end else if (in_data == 8'h0c) begin
        state_d   = CLEAR;
        clr_cnt_d = 8'd0;
      end
    end
  end
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= 8'd0;
      cx_q        <= 4'd0;
      cy_q        <= 4'd0;
      char_code_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      char_code_q <= mem[char_xy];
    end
  end
  // no reset on the array; the forced clear after reset blanks it
  always_ff @(posedge pclk) begin
    if (we && !rst) mem[waddr] <= wdata;
  end
`ifdef CURSOR_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d, cursor_on_q, cursor_on_d;
  always_comb begin
    blink_cnt_d = blink_cnt_q == BW'(BLINK_DIV - 1) ? '0 : blink_cnt_q + 1'b1;
    phase_d     = blink_cnt_q == BW'(BLINK_DIV - 1) ? !phase_q : phase_q;
    cursor_on_d = char_xy == {cx_q, cy_q} && phase_q && state_q == IDLE;
  end
  always_ff @(posedge pclk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      cursor_on_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      cursor_on_q <= cursor_on_d;
    end
  end
  assign cursor_on = cursor_on_q;
`else
  assign cursor_on = 1'b0;
`endif
endmodule

// File: tb/tb_text_buffer_ctrl.sv
// tb_text_buffer_ctrl: random and directed byte streams checked against a cell-array/linear-cursor model.
module tb_text_buffer_ctrl;
  logic       pclk = 1'b0, rst = 1'b1, in_valid = 1'b0, clr_req = 1'b0;
  logic [7:0] in_data = 8'h00, char_xy = 8'h00;
  logic       in_ready, busy, cursor_on;
  logic [7:0] char_code;
  logic [3:0] cursor_x, cursor_y;
  int         total = 0, bad = 0;
  logic [7:0] mm [256];
  int         mpos = 0;

  text_buffer_ctrl #(.CLR_CHAR(8'h20), .BLINK_DIV(4)) dut (
    .pclk(pclk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .clr_req(clr_req), .char_xy(char_xy), .char_code(char_code), .busy(busy),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_on(cursor_on)
  );

  always #5 pclk = ~pclk;

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic chk_cur;
    check("cur_x", 32'(cursor_x), 32'(mpos % 16));
    check("cur_y", 32'(cursor_y), 32'(mpos / 16));
  endtask

  task automatic wait_clear;
    int n = 0;
    while (busy === 1'b1 && n < 300) begin
      tick;
      n++;
    end
    check("clr_len", 32'(n), 32'd256);
    for (int i = 0; i < 256; i++) mm[i] = 8'h20;
    mpos = 0;
  endtask

  task automatic rd(input logic [7:0] a);
    char_xy = a;
    tick;
    check("rd", 32'(char_code), 32'(mm[a]));
  endtask

  task automatic model(input logic [7:0] b);
    int x = mpos % 16, y = mpos / 16;
    if (b >= 8'h20 && b <= 8'h7e) begin
      mm[x * 16 + y] = b;
      mpos = (mpos + 1) % 256;
    end else if (b == 8'h0d) mpos = y * 16;
    else if (b == 8'h0a) mpos = ((y + 1) % 16) * 16 + x;
    else if (b == 8'h08) begin
      if (mpos > 0) mpos--;
      mm[(mpos % 16) * 16 + mpos / 16] = 8'h20;
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    check("rdy", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    model(b);
    if (b == 8'h0c) begin
      check("ff_busy", 32'(busy), 32'd1);
      wait_clear;
    end
    chk_cur;
  endtask

  initial begin
    repeat (2) @(posedge pclk);
    #1;
    check("rst_code", 32'(char_code), 32'd0);
    check("rst_cx", 32'(cursor_x), 32'd0);
    check("rst_cy", 32'(cursor_y), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rdy", 32'(in_ready), 32'd0);
    check("rst_on", 32'(cursor_on), 32'd0);
    rst = 1'b0;
    wait_clear;
    check("post_rdy", 32'(in_ready), 32'd1);
    chk_cur;
    for (int a = 0; a < 256; a++) rd(8'(a));

    send(8'h41);
    send(8'h42);
    rd(8'h00);
    check("cell_a", 32'(char_code), 32'h41);
    rd(8'h10);
    check("cell_b", 32'(char_code), 32'h42);
    check("ab_x", 32'(cursor_x), 32'd2);

    send(8'h0c);
    repeat (16) send(8'h30);
    check("wrap_x", 32'(cursor_x), 32'd0);
    check("wrap_y", 32'(cursor_y), 32'd1);
    repeat (239) send(8'h2e);
    check("br_x", 32'(cursor_x), 32'd15);
    check("br_y", 32'(cursor_y), 32'd15);
    send(8'h58);
    rd(8'hff);
    check("cell_ff", 32'(char_code), 32'h58);
    check("top_x", 32'(cursor_x), 32'd0);
    check("top_y", 32'(cursor_y), 32'd0);

    repeat (53) send(8'h41);
    send(8'h0d);
    check("cr", {cursor_x, cursor_y}, 32'h03);
    send(8'h0a);
    check("lf", {cursor_x, cursor_y}, 32'h04);
    send(8'h08);
    check("bs", {cursor_x, cursor_y}, 32'hf3);
    rd(8'hf3);
    check("bs_cell", 32'(char_code), 32'h20);
    send(8'h0c);
    send(8'h08);
    check("bs00", {cursor_x, cursor_y}, 32'h00);
    rd(8'h00);
    send(8'h07);
    check("bel", {cursor_x, cursor_y}, 32'h00);

    repeat (200) begin
      int r = $urandom_range(0, 99);
      logic [7:0] b;
      b = r < 70 ? 8'($urandom_range(32, 126)) : r < 78 ? 8'h0d : r < 86 ? 8'h0a :
          r < 95 ? 8'h08 : r < 99 ? 8'h07 : 8'h0c;
      send(b);
      repeat ($urandom_range(0, 2)) tick;
    end
    repeat (64) rd(8'($urandom_range(0, 255)));

    in_data  = 8'h41;
    in_valid = 1'b1;
    clr_req  = 1'b1;
    #1;
    check("prio_rdy", 32'(in_ready), 32'd0);
    tick;
    clr_req = 1'b0;
    check("prio_busy", 32'(busy), 32'd1);
    begin
      int n = 0;
      while (busy === 1'b1 && n < 300) begin
        check("clr_rdy", 32'(in_ready), 32'd0);
        tick;
        n++;
      end
      in_valid = 1'b0;
      check("prio_len", 32'(n), 32'd256);
    end
    for (int i = 0; i < 256; i++) mm[i] = 8'h20;
    mpos = 0;
    chk_cur;
    for (int a = 0; a < 256; a++) rd(8'(a));

    repeat (18) send(8'h41);
    check("bl_pos", {cursor_x, cursor_y}, 32'h21);
    char_xy = 8'h21;
`ifdef CURSOR_BLINK_EN
    begin
      int last = -1;
      logic prev;
      tick;
      prev = cursor_on;
      for (int i = 0; i < 30; i++) begin
        tick;
        if (cursor_on !== prev) begin
          if (last >= 0) check("blink_run", 32'(i - last), 32'd4);
          last = i;
          prev = cursor_on;
        end
      end
      check("blink_seen", 32'(last >= 0), 32'd1);
    end
    char_xy = 8'h22;
    repeat (10) begin
      tick;
      check("blink_off", 32'(cursor_on), 32'd0);
    end
`else
    repeat (12) begin
      tick;
      check("no_blink", 32'(cursor_on), 32'd0);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
